mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: Mult_Div_Unit

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand and HI/LO width.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Start_i, input, 1 bit: request an operation, sampled only in IDLE.
REQ-005 The block SHALL have port Op_i, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port Operand_A_i, input, N bits: rs value, taken from register-file Read_Data_1.
REQ-007 The block SHALL have port Operand_B_i, input, N bits: rt value, taken from register-file Read_Data_2.
REQ-008 The block SHALL have port Mthi_i, input, 1 bit: write Operand_A_i into HI.
REQ-009 The block SHALL have port Mtlo_i, input, 1 bit: write Operand_A_i into LO.
REQ-010 The block SHALL have port Busy_o, output, 1 bit: an operation is in progress.
REQ-011 The block SHALL have port Done_o, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port Div_By_Zero_o, output, 1 bit: qualifies Done_o for DIV/DIVU with divisor 0.
REQ-013 The block SHALL have ports Hi_o and Lo_o, outputs, N bits each: registered HI and LO values, consumed by the MFHI/MFLO write-back path.

Function
REQ-014 The FSM SHALL use states IDLE, RUN and ADJ; reset forces IDLE.
REQ-015 Start_i high in IDLE at edge E0 SHALL latch Op_i, Operand_A_i and Operand_B_i, clear a 5-bit iteration counter and enter RUN; later operand changes have no effect.
REQ-016 RUN SHALL perform one iteration per edge (E1..E32): shift-add multiply, or restoring divide, on operand magnitudes; after 32 iterations it enters ADJ.
REQ-017 The edge leaving ADJ (E33) SHALL write HI/LO, pulse Done_o high for exactly the following cycle, and return to IDLE.
REQ-018 Busy_o SHALL be high from E0 through E33 (33 cycles) and low otherwise; Done_o and Busy_o are never high together.
REQ-019 Multiply SHALL give HI:LO = the 2N-bit product; MULT is two's-complement signed, MULTU is unsigned.
REQ-020 Divide SHALL give LO = quotient truncated toward zero and HI = remainder.
REQ-021 For DIV, the quotient sign SHALL be signA XOR signB and the remainder sign SHALL equal signA; sign correction is applied in ADJ.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0 with no error flag.
REQ-023 A divisor of 0 SHALL still take 33 cycles and give HI=dividend as latched, LO=all ones, with Div_By_Zero_o high in the same cycle as Done_o (0 otherwise).
REQ-024 Start_i, Mthi_i and Mtlo_i SHALL be ignored while Busy_o is high.
REQ-025 In IDLE, Mthi_i/Mtlo_i SHALL update HI/LO at the next edge, and both may be asserted together.
REQ-026 If Start_i and Mthi_i/Mtlo_i are asserted together in IDLE, Start_i SHALL win and the moves are dropped.
REQ-027 HI/LO SHALL hold their values between writes.

Reset
REQ-028 While reset is high at an edge, the block SHALL force IDLE, HI=0, LO=0, Busy_o=0, Done_o=0, Div_By_Zero_o=0 and counter=0, overriding all other inputs.
REQ-029 Reset mid-operation SHALL abort the operation with no Done_o pulse and leave HI/LO at 0.
REQ-030 Start_i SHALL be accepted at the first edge after reset deasserts.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> at E33, HI=0xFFFFFFFE, LO=0x00000001; Done_o high for one cycle; Busy_o high for exactly 33 cycles.
REQ-032 MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-033 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 DIVU 100 / 0 -> HI=0x00000064, LO=0xFFFFFFFF, Div_By_Zero_o=1 in the Done_o cycle.
REQ-035 Mthi_i with A=0x12345678 in IDLE -> Hi_o=0x12345678 next cycle; Start_i plus Mtlo_i in the same cycle -> LO comes only from the operation result.
REQ-036 Start MULTU 5 x 6; at E5 drive Start_i, Mthi_i and new operands -> all ignored, result HI=0, LO=30; repeat with reset at E10 -> Busy_o=0, HI=LO=0, and no Done_o thereafter.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32 shift-add or restoring-divide
// steps on operand magnitudes, then one sign-adjust cycle that writes HI/LO.
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Start_i,
    input  logic [1:0]   Op_i,
    input  logic [N-1:0] Operand_A_i,
    input  logic [N-1:0] Operand_B_i,
    input  logic         Mthi_i,
    input  logic         Mtlo_i,
    output logic         Busy_o,
    output logic         Done_o,
    output logic         Div_By_Zero_o,
    output logic [N-1:0] Hi_o,
    output logic [N-1:0] Lo_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] ADJ  = 2'd2;

    logic [1:0]   state;
    logic [CW-1:0] cnt;
    logic [1:0]   op;
    logic [N-1:0] a_lat, b_mag, acc_hi, acc_lo, hi_q, lo_q;
    logic         neg_q, neg_r, done_q, dbz_q;

    logic         start_sa, start_sb;
    logic [N-1:0] start_a_mag, start_b_mag;
    logic [N:0]   add_sum, rem_sh, rem_sub;
    logic         div_ge, is_div, b_zero;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0] q_fix, r_fix;

    always_comb begin
        start_sa    = ~Op_i[0] & Operand_A_i[N-1];
        start_sb    = ~Op_i[0] & Operand_B_i[N-1];
        start_a_mag = start_sa ? (~Operand_A_i + 1'b1) : Operand_A_i;
        start_b_mag = start_sb ? (~Operand_B_i + 1'b1) : Operand_B_i;

        is_div  = op[1];
        b_zero  = (b_mag == '0);
        add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : {(N+1){1'b0}});
        rem_sh  = {acc_hi, acc_lo[N-1]};
        rem_sub = rem_sh - {1'b0, b_mag};
        div_ge  = (rem_sh >= {1'b0, b_mag});

        prod_fix = neg_q ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
        q_fix    = neg_q ? (~acc_lo + 1'b1) : acc_lo;
        r_fix    = neg_r ? (~acc_hi + 1'b1) : acc_hi;
    end

    // Multiplier and dividend share acc_lo; the same init serves both operations.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            a_lat  <= '0;
            b_mag  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start_i) begin
                        op     <= Op_i;
                        a_lat  <= Operand_A_i;
                        b_mag  <= start_b_mag;
                        acc_hi <= '0;
                        acc_lo <= start_a_mag;
                        neg_q  <= start_sa ^ start_sb;
                        neg_r  <= start_sa;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        if (Mthi_i) hi_q <= Operand_A_i;
                        if (Mtlo_i) lo_q <= Operand_A_i;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        acc_hi <= div_ge ? rem_sub[N-1:0] : rem_sh[N-1:0];
                        acc_lo <= {acc_lo[N-2:0], div_ge};
                    end else begin
                        {acc_hi, acc_lo} <= {add_sum, acc_lo[N-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) state <= ADJ;
                end
                ADJ: begin
                    if (is_div) begin
                        if (b_zero) begin
                            hi_q  <= a_lat;
                            lo_q  <= '1;
                            dbz_q <= 1'b1;
                        end else begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy_o        = (state != IDLE);
    assign Done_o        = done_q;
    assign Div_By_Zero_o = dbz_q;
    assign Hi_o          = hi_q;
    assign Lo_o          = lo_q;

endmodule
